// File: rtl/timer_run_ctrl.sv
// Run-control sequencer for the 4-digit BCD timer: turns debounced button levels
// into one-cycle increment/clear commands, and owns the 1 Hz tick, blink and digit scan.
module timer_run_ctrl #(
  parameter int CLK_HZ  = 1000,
  parameter int TICK_HZ = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        mode,
  input  logic        clr,
  input  logic [15:0] count_bcd,
  output logic        cnt_inc,
  output logic        cnt_clr,
  output logic        auto,
  output logic        run,
  output logic        done,
  output logic        blank,
  output logic [1:0]  sel
);
  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int HALF = DIV / 2;
  localparam int DW   = $clog2(DIV);
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t          state, st_n;
  logic [DW-1:0]   div_q, div_n;
  logic [BW-1:0]   bcnt, bcnt_n;
  logic            phase, ph_n;
  logic            clr_p, stop_p, start_p, mode_p;
  logic            e_clr, e_stop, e_start, e_mode;
  logic            full, wrap;
  logic            auto_n, inc_n, clr_n, blank_n;

  assign e_clr   = clr   & ~clr_p;
  assign e_stop  = stop  & ~stop_p;
  assign e_start = start & ~start_p;
  assign e_mode  = mode  & ~mode_p;
  assign full    = (count_bcd == 16'h9999);
  assign wrap    = (div_q == DW'(DIV - 1));

  always_comb begin
    st_n   = state;
    auto_n = auto;
    div_n  = div_q;
    inc_n  = 1'b0;
    clr_n  = 1'b0;
    if (e_clr) begin
      clr_n = 1'b1;
      st_n  = IDLE;
      div_n = '0;
    end else begin
      case (state)
        IDLE: begin
          // a stop edge, though ignored here, still outranks start and mode
          if (e_stop) begin
          end else if (e_start) begin
            if (auto) begin
              st_n  = RUN;
              div_n = '0;
            end else if (full) st_n = DONE;
            else inc_n = 1'b1;
          end else if (e_mode) auto_n = ~auto;
        end
        RUN: begin
          if (e_stop) st_n = PAUSE;
          else begin
            div_n = wrap ? '0 : div_q + 1'b1;
            if (wrap) begin
              if (full) st_n = DONE;
              else inc_n = 1'b1;
            end
          end
        end
        PAUSE: if (!e_stop && e_start) st_n = RUN;
        default: ;
      endcase
    end

    bcnt_n = bcnt;
    ph_n   = phase;
    if (st_n == RUN) begin
      bcnt_n = '0;
      ph_n   = 1'b0;
    end else if (bcnt == BW'(HALF - 1)) begin
      bcnt_n = '0;
      ph_n   = ~phase;
    end else bcnt_n = bcnt + 1'b1;

    blank_n = ph_n & (((st_n == IDLE) & ~auto_n) | (st_n == PAUSE) | (st_n == DONE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_q   <= '0;
      bcnt    <= '0;
      phase   <= 1'b0;
      clr_p   <= 1'b1;
      stop_p  <= 1'b1;
      start_p <= 1'b1;
      mode_p  <= 1'b1;
      auto    <= 1'b0;
      run     <= 1'b0;
      done    <= 1'b0;
      cnt_inc <= 1'b0;
      cnt_clr <= 1'b1;
      blank   <= 1'b0;
      sel     <= '0;
    end else begin
      state   <= st_n;
      div_q   <= div_n;
      bcnt    <= bcnt_n;
      phase   <= ph_n;
      clr_p   <= clr;
      stop_p  <= stop;
      start_p <= start;
      mode_p  <= mode;
      auto    <= auto_n;
      run     <= (st_n == RUN);
      done    <= (st_n == DONE);
      cnt_inc <= inc_n;
      cnt_clr <= clr_n;
      blank   <= blank_n;
      sel     <= sel + 2'd1;
    end
  end
endmodule

// File: tb/tb_timer_run_ctrl.sv
// Bench for timer_run_ctrl: expected command pulses are queued with their cycle,
// a negedge monitor pops and compares whenever cnt_inc/cnt_clr fires.
module tb_timer_run_ctrl;
  logic        clk = 0, rst = 1;
  logic        start = 1, stop = 0, mode = 0, clr = 0;
  logic [15:0] count_bcd = 16'h0000;
  logic        cnt_inc, cnt_clr, auto, run, done, blank;
  logic [1:0]  sel;

  timer_run_ctrl #(.CLK_HZ(1000), .TICK_HZ(1)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .clr(clr),
    .count_bcd(count_bcd), .cnt_inc(cnt_inc), .cnt_clr(cnt_clr), .auto(auto),
    .run(run), .done(done), .blank(blank), .sel(sel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  bit mon_en = 0;
  typedef struct {bit is_clr; int at;} ev_t;
  ev_t sbq[$];

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic push(bit c, int at);
    ev_t e;
    e.is_clr = c;
    e.at     = at;
    sbq.push_back(e);
  endtask

  task automatic see(bit c);
    ev_t e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s: pulse at cycle %0d, none expected", c ? "clr" : "inc", cyc);
    end else begin
      e = sbq.pop_front();
      if (e.is_clr !== c || e.at != cyc) begin
        bad++;
        $display("FAIL pulse: got %s at cycle %0d expected %s at cycle %0d",
                 c ? "clr" : "inc", cyc, e.is_clr ? "clr" : "inc", e.at);
      end
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    while (sbq.size() > 0 && sbq[0].at < cyc) begin
      total++;
      bad++;
      $display("FAIL missed_%s: expected at cycle %0d, absent through %0d",
               sbq[0].is_clr ? "clr" : "inc", sbq[0].at, cyc);
      void'(sbq.pop_front());
    end
    if (cnt_clr) see(1'b1);
    if (cnt_inc) see(1'b0);
  end

  task automatic wait_blank(output int t);
    logic b0;
    b0 = blank;
    t  = -1;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (blank !== b0) begin t = cyc; return; end
    end
    chk("blank_toggle_timeout", 1, 0);
  endtask

  int s, q, t1, t2, t3;

  initial begin
    // reset with start held high
    step(3);
    rst = 0; mon_en = 1;
    push(1'b1, cyc);
    chk("rst_run", run, 0);
    chk("rst_done", done, 0);
    chk("rst_auto", auto, 0);
    chk("rst_blank", blank, 0);
    chk("rst_sel", sel, 0);
    chk("rst_inc", cnt_inc, 0);
    step(2); start = 0;
    step(2); start = 1; push(1'b0, cyc + 1);
    step();  start = 0;

    // sel free-runs across a mode toggle
    for (int i = 0; i < 8; i++) begin
      chk("sel_seq", sel, (cyc - 3) % 4);
      if (i == 2) mode = 1;
      if (i == 3) mode = 0;
      step();
    end
    chk("auto_on", auto, 1);
    chk("blank_idle_auto", blank, 0);

    // auto run: ticks every 1000 cycles after entry
    start = 1; s = cyc;
    push(1'b0, s + 1001); push(1'b0, s + 2001); push(1'b0, s + 3001);
    step(); start = 0;
    chk("run_on", run, 1);
    while (cyc < s + 3401) begin
      chk("blank_run", blank, 0);
      chk("run_hold", run, 1);
      step();
    end

    // stop when divider reaches 400, pause, resume
    stop = 1; step(); stop = 0;
    chk("paused", run, 0);
    for (int i = 0; i < 5000; i++) begin
      if (i % 50 == 0) chk("pause_run", run, 0);
      step();
    end
    start = 1; q = cyc + 1; push(1'b0, q + 600);
    step(); start = 0;
    chk("resume", run, 1);
    while (cyc < q + 600) step();

    // overflow hold at the next tick
    count_bcd = 16'h9999;
    while (cyc < q + 1600) step();
    chk("done_set", done, 1);
    chk("done_run", run, 0);
    wait_blank(t1); wait_blank(t2); wait_blank(t3);
    chk("blink_gap1", t2 - t1, 500);
    chk("blink_gap2", t3 - t2, 500);
    start = 1; step(); start = 0; step(5);
    chk("done_ignores_start", done, 1);
    clr = 1; push(1'b1, cyc + 1); step(); clr = 0;
    chk("clr_done", done, 0);
    chk("clr_run", run, 0);
    chk("clr_auto_kept", auto, 1);
    count_bcd = 16'h0000;

    // manual start at 9999 goes to DONE without increment
    step(); mode = 1; step(); mode = 0;
    chk("auto_off", auto, 0);
    count_bcd = 16'h9999; start = 1; step(); start = 0;
    chk("manual_full_done", done, 1);
    clr = 1; push(1'b1, cyc + 1); step(); clr = 0;
    chk("manual_clr_done", done, 0);
    count_bcd = 16'h0000;

    // clr and start edges together: clear only
    step(); clr = 1; start = 1; push(1'b1, cyc + 1);
    step(); clr = 0; start = 0; step(2);
    chk("clr_start_done", done, 0);
    chk("clr_start_run", run, 0);

    // stop and start together in PAUSE stays paused
    mode = 1; step(); mode = 0;
    start = 1; step(); start = 0;
    chk("run_again", run, 1);
    step(3); stop = 1; step(); stop = 0;
    chk("pause_again", run, 0);
    step(2); stop = 1; start = 1; step(); stop = 0; start = 0;
    chk("pause_stop_start", run, 0);
    step(5);
    chk("pause_stays", run, 0);

    step(5);
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
